// File: rtl/knn_voter_pkg.sv
// Shared constants and FSM encoding for the KNN classification back-end.
// The sorter imports this package too, so K and IDXW cannot diverge.
package knn_voter_pkg;
  localparam int K_DEF    = 4;
  localparam int IDXW_DEF = 8;
  localparam int LW_DEF   = 4;
  localparam int WCW      = $clog2(K_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/knn_voter_if.sv
// Control, sorter-select and label-memory signals of the KNN voter.
// The master modport is the voter side; slave is the software/sorter/memory side.
interface knn_voter_if
  import knn_voter_pkg::*;
#(
  parameter int IDXW = IDXW_DEF,
  parameter int LW   = LW_DEF
);
  logic            start;
  logic [IDXW-1:0] count;
  logic [1:0]      sel;
  logic [IDXW-1:0] idx_in;
  logic            lbl_en;
  logic [IDXW-1:0] lbl_addr;
  logic [LW-1:0]   lbl_data;
  logic            busy;
  logic            done;
  logic [LW-1:0]   label;
  logic [WCW-1:0]  win_cnt;

  modport master (
    input  start, count, idx_in, lbl_data,
    output sel, lbl_en, lbl_addr, busy, done, label, win_cnt
  );

  modport slave (
    output start, count, idx_in, lbl_data,
    input  sel, lbl_en, lbl_addr, busy, done, label, win_cnt
  );
endinterface

// File: rtl/knn_vote_hist.sv
// Per-class vote histogram with clear, increment-at-address and a one-class-per-cycle
// argmax scan; strict-greater compare so ties resolve to the lowest class.
module knn_vote_hist
  import knn_voter_pkg::*;
#(
  parameter int LW = LW_DEF,
  parameter int CW = WCW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_en,
  input  logic [LW-1:0] inc_addr,
  input  logic          scan_en,
  output logic          scan_last,
  output logic [LW-1:0] scan_lbl,
  output logic [CW-1:0] scan_cnt
);
  localparam int NC = 2 ** LW;

  logic [CW-1:0] hist_vec [NC];
  logic [LW-1:0] c_reg;
  logic [LW-1:0] best_lbl_reg;
  logic [CW-1:0] best_cnt_reg;
  logic [LW-1:0] base_lbl;
  logic [CW-1:0] base_cnt;
  logic [CW-1:0] cur_cnt;

  // K votes can never overflow a CW-bit counter, so no saturation logic is needed
  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_cls
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst || clr)
          cnt_reg <= '0;
        else if (inc_en && (inc_addr == LW'(gi)))
          cnt_reg <= cnt_reg + 1'b1;
      end
      assign hist_vec[gi] = cnt_reg;
    end
  endgenerate

  assign cur_cnt   = hist_vec[c_reg];
  assign scan_last = (c_reg == '1);

  always_comb begin
    base_lbl = best_lbl_reg;
    base_cnt = best_cnt_reg;
    if (c_reg == '0) begin
      base_lbl = '0;
      base_cnt = '0;
    end
    scan_lbl = base_lbl;
    scan_cnt = base_cnt;
    if (cur_cnt > base_cnt) begin
      scan_lbl = c_reg;
      scan_cnt = cur_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      c_reg        <= '0;
      best_lbl_reg <= '0;
      best_cnt_reg <= '0;
    end else if (scan_en) begin
      c_reg        <= c_reg + 1'b1;
      best_lbl_reg <= scan_lbl;
      best_cnt_reg <= scan_cnt;
    end
  end
endmodule

// File: rtl/knn_voter.sv
// KNN classification back-end: walks the sorter's K slots, fetches each neighbour's
// label, accumulates a class histogram and reports the majority label.
module knn_voter
  import knn_voter_pkg::*;
#(
  parameter int K    = K_DEF,
  parameter int IDXW = IDXW_DEF,
  parameter int LW   = LW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  knn_voter_if.master  bus
);
  state_t         state_reg, state_next;
  logic           accept;
  logic [1:0]     i_reg;
  logic           en_d_reg;
  logic [LW-1:0]  label_reg;
  logic [WCW-1:0] win_cnt_reg;
  logic           fetch;
  logic           scan_last;
  logic [LW-1:0]  scan_lbl;
  logic [WCW-1:0] scan_cnt;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: if (i_reg == 2'(K - 1)) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_SCAN;
      ST_SCAN:  if (scan_last) state_next = ST_DONE;
      ST_DONE: begin
        state_next = ST_IDLE;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Slots beyond count still hold the sorter's reset index and must not vote
  assign fetch        = (state_reg == ST_FETCH);
  assign bus.sel      = fetch ? i_reg : 2'd0;
  assign bus.lbl_addr = fetch ? bus.idx_in : '0;
  assign bus.lbl_en   = fetch && (IDXW'(i_reg) < bus.count);
  assign bus.busy     = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN) ||
                        (state_reg == ST_SCAN);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.label    = label_reg;
  assign bus.win_cnt  = win_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_reg    <= '0;
      en_d_reg <= 1'b0;
    end else begin
      en_d_reg <= bus.lbl_en;
      if (accept)     i_reg <= '0;
      else if (fetch) i_reg <= i_reg + 1'b1;
    end
  end

  // Capture the final argmax on the last scan step so the result is visible with done
  always_ff @(posedge clk) begin
    if (rst) begin
      label_reg   <= '0;
      win_cnt_reg <= '0;
    end else if ((state_reg == ST_SCAN) && scan_last) begin
      label_reg   <= scan_lbl;
      win_cnt_reg <= scan_cnt;
    end
  end

  knn_vote_hist #(
    .LW (LW),
    .CW (WCW)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .inc_en    (en_d_reg),
    .inc_addr  (bus.lbl_data),
    .scan_en   (state_reg == ST_SCAN),
    .scan_last (scan_last),
    .scan_lbl  (scan_lbl),
    .scan_cnt  (scan_cnt)
  );
endmodule

// File: tb/tb_knn_voter.sv
// Directed-vector bench for knn_voter with a combinational sorter model and a
// one-cycle-latency label memory model.
module tb_knn_voter;
  import knn_voter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  knn_voter_if #(.IDXW(8), .LW(4)) bus ();

  knn_voter #(.K(4), .IDXW(8), .LW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] slot_idx [4];
  logic [3:0] mem [256];

  assign bus.idx_in = slot_idx[bus.sel];

  always @(posedge clk) begin
    if (bus.lbl_en) bus.lbl_data <= mem[bus.lbl_addr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vote(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3,
                          input logic [3:0] l0, input logic [3:0] l1,
                          input logic [3:0] l2, input logic [3:0] l3,
                          input logic [7:0] cnt);
    slot_idx[0] = s0; slot_idx[1] = s1; slot_idx[2] = s2; slot_idx[3] = s3;
    mem[s0] = l0; mem[s1] = l1; mem[s2] = l2; mem[s3] = l3;
    bus.count = cnt;
  endtask

  // Call with the bench positioned in cycle 0; with chain=1 it returns inside the done cycle
  task automatic do_vote(input string tag, input int exp_lbl, input int exp_wc, input bit chain);
    int done_cyc = -1;
    int stray    = 0;
    int en_mask  = 0;
    int cnt      = int'(bus.count);
    int exp_mask = (cnt >= 4) ? 15 : ((1 << cnt) - 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      if (cyc == 1) check({tag, "_busy_c1"}, int'(bus.busy), 1);
      if (bus.lbl_en) begin
        if (cyc <= 4) begin
          en_mask |= (1 << (cyc - 1));
          check({tag, "_addr"}, int'(bus.lbl_addr), int'(slot_idx[cyc - 1]));
        end else begin
          stray++;
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        check({tag, "_label"}, int'(bus.label), exp_lbl);
        check({tag, "_win_cnt"}, int'(bus.win_cnt), exp_wc);
        check({tag, "_busy_done"}, int'(bus.busy), 0);
      end else begin
        tick();
      end
    end
    check({tag, "_done_cyc"}, done_cyc, 22);
    check({tag, "_en_mask"}, en_mask, exp_mask);
    check({tag, "_stray_en"}, stray, 0);
    $display("vote %s: count=%0d label=%0d win_cnt=%0d done_cycle=%0d",
             tag, cnt, bus.label, bus.win_cnt, done_cyc);
    if (!chain) begin
      tick();
      check({tag, "_done_pulse"}, int'(bus.done), 0);
      check({tag, "_label_hold"}, int'(bus.label), exp_lbl);
      check({tag, "_wc_hold"}, int'(bus.win_cnt), exp_wc);
    end
  endtask

  initial begin
    int seen;
    for (int a = 0; a < 256; a++) mem[a] = 4'd0;
    for (int s = 0; s < 4; s++) slot_idx[s] = 8'd0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.count = 8'd0;
    tick(); tick(); tick();
    check("rst_busy",     int'(bus.busy),     0);
    check("rst_done",     int'(bus.done),     0);
    check("rst_label",    int'(bus.label),    0);
    check("rst_win_cnt",  int'(bus.win_cnt),  0);
    check("rst_lbl_en",   int'(bus.lbl_en),   0);
    check("rst_sel",      int'(bus.sel),      0);
    check("rst_lbl_addr", int'(bus.lbl_addr), 0);
    rst = 1'b0;
    tick();

    set_vote(8'd5, 8'd9, 8'd2, 8'd7, 4'd3, 4'd3, 4'd1, 4'd3, 8'd10);
    do_vote("majority", 3, 3, 1'b0);

    set_vote(8'd11, 8'd12, 8'd13, 8'd14, 4'd1, 4'd2, 4'd1, 4'd2, 8'd10);
    do_vote("tie", 1, 2, 1'b0);

    set_vote(8'd20, 8'd21, 8'd0, 8'd0, 4'd6, 4'd4, 4'd9, 4'd9, 8'd2);
    do_vote("partial", 4, 1, 1'b0);

    set_vote(8'd30, 8'd31, 8'd32, 8'd33, 4'd15, 4'd15, 4'd15, 4'd15, 8'd4);
    do_vote("edge15", 15, 4, 1'b0);

    bus.count = 8'd0;
    do_vote("count0", 0, 0, 1'b0);

    // Second vote's start lands in the first vote's done cycle; a stale histogram would pick class 3
    set_vote(8'd5, 8'd9, 8'd2, 8'd7, 4'd3, 4'd3, 4'd1, 4'd3, 8'd10);
    do_vote("b2b_a", 3, 3, 1'b1);
    set_vote(8'd50, 8'd51, 8'd52, 8'd53, 4'd8, 4'd3, 4'd8, 4'd0, 8'd10);
    do_vote("b2b_b", 8, 2, 1'b0);

    set_vote(8'd40, 8'd41, 8'd42, 8'd43, 4'd7, 4'd7, 4'd7, 4'd7, 8'd10);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ignore_addr_c4", int'(bus.lbl_addr), 43);
    check("ignore_en_c4",   int'(bus.lbl_en),   1);
    tick();
    check("ignore_en_c5",   int'(bus.lbl_en),   0);
    check("ignore_busy_c5", int'(bus.busy),     1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",    int'(bus.busy),    0);
    check("abort_done",    int'(bus.done),    0);
    check("abort_label",   int'(bus.label),   0);
    check("abort_win_cnt", int'(bus.win_cnt), 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) seen++;
      tick();
    end
    check("abort_no_done", seen, 0);
    $display("abort: done pulses after reset=%0d", seen);

    set_vote(8'd44, 8'd45, 8'd46, 8'd47, 4'd2, 4'd5, 4'd5, 4'd9, 8'd10);
    do_vote("fresh", 5, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
